// File: rtl/mseries_check.sv
// mseries_check: locks onto a received maximal-length (M-)sequence and
// counts bit errors once locked.
//
// The checker first loads M received bits into a local generator register,
// then verifies that LOCK_N consecutive received bits match the generator's
// prediction. Once locked, the generator free-runs: it feeds back its own
// predicted bit, so a single flipped input bit shows up as exactly one
// error. If LOSS_N errors land inside one WIN_LEN-bit window, lock is
// dropped and the fill/verify process starts again.
//
// Parameters:
//   M        sequence order (2..16), selects the feedback taps
//   LOCK_N   consecutive correct predictions needed to declare lock
//   LOSS_N   errors within one window that force loss of lock
//   WIN_LEN  loss-detection window length in valid bits
//   CNT_W    width of err_cnt and bit_cnt
//
// Ports:
//   clk_sig   in   sole clock, rising edge
//   rst_sig   in   synchronous active-low reset
//   in_valid  in   in_sig is sampled on this edge; nothing advances without it
//   in_sig    in   received sequence bit
//   clr_sig   in   synchronous clear of err_cnt and bit_cnt
//   lock_sig  out  registered, high exactly while locked
//   err_sig   out  one-cycle pulse per bit error seen while locked
//   err_cnt   out  saturating count of errors seen while locked
//   bit_cnt   out  saturating count of valid bits checked while locked

module mseries_check #(
   parameter int M       = 4,
   parameter int LOCK_N  = 8,
   parameter int LOSS_N  = 4,
   parameter int WIN_LEN = 64,
   parameter int CNT_W   = 16
) (
   input  logic             clk_sig,
   input  logic             rst_sig,
   input  logic             in_valid,
   input  logic             in_sig,
   input  logic             clr_sig,
   output logic             lock_sig,
   output logic             err_sig,
   output logic [CNT_W-1:0] err_cnt,
   output logic [CNT_W-1:0] bit_cnt
);

   typedef enum logic [1:0] {ST_FILL, ST_VERIFY, ST_LOCKED} state_t;

   localparam int FILL_W  = $clog2(M + 1);
   localparam int MATCH_W = $clog2(LOCK_N + 1);
   localparam int WIN_W   = $clog2(WIN_LEN + 1);
   localparam int WERR_W  = $clog2(LOSS_N + 1);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   // Feedback tap mask for each supported order; bit k set means r[k] is a tap.
   function automatic logic [15:0] tap_mask(input int order);
      case (order)
         2:       return 16'h0003;
         3:       return 16'h0006;
         4:       return 16'h000C;
         5:       return 16'h0014;
         6:       return 16'h0030;
         7:       return 16'h0048;
         8:       return 16'h00B8;
         9:       return 16'h0110;
         10:      return 16'h0240;
         11:      return 16'h0500;
         12:      return 16'h0CA0;
         13:      return 16'h1B00;
         14:      return 16'h3088;
         15:      return 16'h6000;
         16:      return 16'hD008;
         default: return 16'h0000;
      endcase
   endfunction

   localparam logic [15:0]  TAP_ALL = tap_mask(M);
   localparam logic [M-1:0] TAPS    = TAP_ALL[M-1:0];

   state_t               state_q, state_d;
   logic [M-1:0]         r_q, r_d;
   logic [FILL_W-1:0]    fill_q, fill_d;
   logic [MATCH_W-1:0]   match_q, match_d;
   logic [WIN_W-1:0]     win_pos_q, win_pos_d;
   logic [WERR_W-1:0]    win_err_q, win_err_d;
   logic                 lock_q, lock_d;
   logic                 err_q, err_d;
   logic [CNT_W-1:0]     err_cnt_q, err_cnt_d;
   logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;

   logic p;
   logic mismatch;
   logic win_wrap;

   assign p        = ^(r_q & TAPS);
   assign mismatch = (in_sig != p);
   assign win_wrap = (win_pos_q == WIN_W'(WIN_LEN - 1));

   // State register: every flop in the block, reset to the fill state with an
   // all-ones generator so the register is never stuck at zero after reset.
   always_ff @(posedge clk_sig) begin
      if (!rst_sig) begin
         state_q   <= ST_FILL;
         r_q       <= '1;
         fill_q    <= '0;
         match_q   <= '0;
         win_pos_q <= '0;
         win_err_q <= '0;
         lock_q    <= 1'b0;
         err_q     <= 1'b0;
         err_cnt_q <= '0;
         bit_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         r_q       <= r_d;
         fill_q    <= fill_d;
         match_q   <= match_d;
         win_pos_q <= win_pos_d;
         win_err_q <= win_err_d;
         lock_q    <= lock_d;
         err_q     <= err_d;
         err_cnt_q <= err_cnt_d;
         bit_cnt_q <= bit_cnt_d;
      end
   end

   // Next-state logic. Only valid cycles move the state, the generator or
   // the fill/match/window counts. While locked the generator shifts in its
   // own prediction rather than the input. A match against an all-zero
   // register does not count, since that is the degenerate lock-up state.
   // An error on the last bit of a window still counts toward loss before
   // the window restarts.
   always_comb begin
      state_d   = state_q;
      r_d       = r_q;
      fill_d    = fill_q;
      match_d   = match_q;
      win_pos_d = win_pos_q;
      win_err_d = win_err_q;
      if (in_valid) begin
         case (state_q)
            ST_FILL: begin
               r_d = {r_q[M-2:0], in_sig};
               if (fill_q == FILL_W'(M - 1)) begin
                  state_d = ST_VERIFY;
                  fill_d  = '0;
                  match_d = '0;
               end else begin
                  fill_d = fill_q + FILL_W'(1);
               end
            end
            ST_VERIFY: begin
               r_d = {r_q[M-2:0], in_sig};
               if (!mismatch && (r_q != '0)) begin
                  if (match_q == MATCH_W'(LOCK_N - 1)) begin
                     state_d   = ST_LOCKED;
                     match_d   = '0;
                     win_pos_d = '0;
                     win_err_d = '0;
                  end else begin
                     match_d = match_q + MATCH_W'(1);
                  end
               end else begin
                  match_d = '0;
               end
            end
            ST_LOCKED: begin
               r_d       = {r_q[M-2:0], p};
               win_pos_d = win_wrap ? '0 : win_pos_q + WIN_W'(1);
               if (mismatch && (win_err_q == WERR_W'(LOSS_N - 1))) begin
                  state_d   = ST_FILL;
                  fill_d    = '0;
                  match_d   = '0;
                  win_pos_d = '0;
                  win_err_d = '0;
               end else if (win_wrap) begin
                  win_err_d = '0;
               end else if (mismatch) begin
                  win_err_d = win_err_q + WERR_W'(1);
               end
            end
            default: begin
               state_d = ST_FILL;
               fill_d  = '0;
               match_d = '0;
            end
         endcase
      end
   end

   // Output logic. lock follows the next state so the registered flag is high
   // exactly while the state is locked. The error pulse is rebuilt every cycle
   // so it lasts one cycle even across stalls. Clear wins over increment, and
   // both counters stick at all-ones.
   always_comb begin
      lock_d    = (state_d == ST_LOCKED);
      err_d     = in_valid && (state_q == ST_LOCKED) && mismatch;
      err_cnt_d = err_cnt_q;
      bit_cnt_d = bit_cnt_q;
      if (clr_sig) begin
         err_cnt_d = '0;
         bit_cnt_d = '0;
      end else begin
         if (err_d && (err_cnt_q != CNT_MAX)) begin
            err_cnt_d = err_cnt_q + CNT_W'(1);
         end
         if (in_valid && (state_q == ST_LOCKED) && (bit_cnt_q != CNT_MAX)) begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
         end
      end
   end

   assign lock_sig = lock_q;
   assign err_sig  = err_q;
   assign err_cnt  = err_cnt_q;
   assign bit_cnt  = bit_cnt_q;

endmodule

// File: tb/tb_mseries_check.sv
// tb_mseries_check: self-checking bench for mseries_check (order 4).
// A behavioural model tracks the received-bit history, the lock phase and
// the statistics, and is compared with two DUT instances every cycle: the
// default one and a copy with 3-bit counters so saturation is reachable.
// Directed table rows and hand-written sequences cover lock timing, single
// errors, loss/relock, reset while locked, stalls, clear and all-zero input.

module tb_mseries_check;

   localparam int M       = 4;
   localparam int LOCK_N  = 8;
   localparam int LOSS_N  = 4;
   localparam int WIN_LEN = 64;
   localparam int CNT_W   = 16;
   localparam int SMALL_W = 3;

   logic clk_sig  = 1'b0;
   logic rst_sig  = 1'b0;
   logic in_valid = 1'b0;
   logic in_sig   = 1'b0;
   logic clr_sig  = 1'b0;

   logic               lock_sig, err_sig;
   logic [CNT_W-1:0]   err_cnt, bit_cnt;
   logic               lock_small, err_small;
   logic [SMALL_W-1:0] err_cnt_small, bit_cnt_small;

   mseries_check #(.M(M), .LOCK_N(LOCK_N), .LOSS_N(LOSS_N), .WIN_LEN(WIN_LEN), .CNT_W(CNT_W)) dut (
      .clk_sig(clk_sig), .rst_sig(rst_sig), .in_valid(in_valid), .in_sig(in_sig),
      .clr_sig(clr_sig), .lock_sig(lock_sig), .err_sig(err_sig),
      .err_cnt(err_cnt), .bit_cnt(bit_cnt));

   mseries_check #(.M(M), .LOCK_N(LOCK_N), .LOSS_N(LOSS_N), .WIN_LEN(WIN_LEN), .CNT_W(SMALL_W)) dut_small (
      .clk_sig(clk_sig), .rst_sig(rst_sig), .in_valid(in_valid), .in_sig(in_sig),
      .clr_sig(clr_sig), .lock_sig(lock_small), .err_sig(err_small),
      .err_cnt(err_cnt_small), .bit_cnt(bit_cnt_small));

   always #5 clk_sig = ~clk_sig;

   int checks   = 0;
   int failures = 0;

   // Transmitted sequence for order 4 and a cursor into it.
   bit periodBits [15] = '{1,1,1,1,0,0,0,1,0,0,1,1,0,1,0};
   int txIdx = 0;

   // Reference model state: history of generator bits (oldest first),
   // lock phase (0 fill, 1 verify, 2 locked) and plain counts.
   int     TAPS [2] = '{3, 2};
   bit     hist [$];
   int     phase, filled, streak, winBit, winErrs;
   bit     expLock, expErr;
   longint errRaw, bitRaw;

   function automatic bit nextTx();
      bit b = periodBits[txIdx];
      txIdx = (txIdx + 1) % 15;
      return b;
   endfunction

   function automatic longint satTo(longint v, int w);
      longint top = (longint'(1) << w) - 1;
      return (v > top) ? top : v;
   endfunction

   // Bit shifted in t shifts ago sits t places from the newest end.
   function automatic bit predict();
      bit x = 1'b0;
      foreach (TAPS[i]) x ^= hist[M - 1 - TAPS[i]];
      return x;
   endfunction

   function automatic void pushBit(bit b);
      hist.push_back(b);
      void'(hist.pop_front());
   endfunction

   function automatic void stepModel(bit rst, bit valid, bit b, bit clr);
      bit pred, allZero;
      if (!rst) begin
         hist.delete();
         for (int i = 0; i < M; i++) hist.push_back(1'b1);
         phase = 0; filled = 0; streak = 0; winBit = 0; winErrs = 0;
         expLock = 0; expErr = 0; errRaw = 0; bitRaw = 0;
         return;
      end
      expErr = 0;
      if (valid) begin
         pred = predict();
         if (phase == 0) begin
            pushBit(b);
            filled++;
            if (filled == M) begin phase = 1; filled = 0; streak = 0; end
         end else if (phase == 1) begin
            allZero = 1;
            foreach (hist[i]) if (hist[i]) allZero = 0;
            pushBit(b);
            if (b == pred && !allZero) begin
               streak++;
               if (streak == LOCK_N) begin phase = 2; streak = 0; winBit = 0; winErrs = 0; end
            end else begin
               streak = 0;
            end
         end else begin
            pushBit(pred);
            bitRaw++;
            winBit++;
            if (b != pred) begin expErr = 1; errRaw++; winErrs++; end
            if (winErrs == LOSS_N) begin
               phase = 0; filled = 0; streak = 0; winBit = 0; winErrs = 0;
            end else if (winBit == WIN_LEN) begin
               winBit = 0; winErrs = 0;
            end
         end
      end
      if (clr) begin errRaw = 0; bitRaw = 0; end
      expLock = (phase == 2);
   endfunction

   task automatic check(input string name, input longint actual, input longint expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
      end
   endtask

   task automatic checkOutput();
      check("lock_sig", lock_sig, expLock);
      check("err_sig", err_sig, expErr);
      check("err_cnt", err_cnt, satTo(errRaw, CNT_W));
      check("bit_cnt", bit_cnt, satTo(bitRaw, CNT_W));
      check("err_cnt_small", err_cnt_small, satTo(errRaw, SMALL_W));
      check("bit_cnt_small", bit_cnt_small, satTo(bitRaw, SMALL_W));
   endtask

   // Drive on the falling edge, advance the model on the rising edge and
   // compare just after it.
   task automatic applyStimulus(input bit rst, input bit valid, input bit b, input bit clr);
      @(negedge clk_sig);
      rst_sig  = rst;
      in_valid = valid;
      in_sig   = b;
      clr_sig  = clr;
      @(posedge clk_sig);
      stepModel(rst, valid, b, clr);
      #1;
      checkOutput();
   endtask

   // One cycle of the transmitted sequence; stalled cycles carry junk data.
   task automatic sendBit(input bit valid, input bit flip, input bit clr);
      bit b;
      if (valid) b = nextTx() ^ flip;
      else       b = 1'($urandom);
      applyStimulus(1'b1, valid, b, clr);
   endtask

   // Feed clean bits until lock appears (bounded); returns the bit count.
   task automatic relock(output int at);
      at = 0;
      for (int k = 1; k <= 20 && at == 0; k++) begin
         sendBit(1'b1, 1'b0, 1'b0);
         if (lock_sig) at = k;
      end
   endtask

   typedef struct {
      bit valid;
      bit flip;
      bit expLock;
      bit expErr;
      int expBitCnt;
   } vec_t;

   vec_t tbl [$];

   initial begin
      int lockAt, pulses, valids;
      bit lockSeen;
      int garbage;

      // Directed table: clean lock from reset, a stall, one error, recovery.
      for (int k = 1; k <= 15; k++)
         tbl.push_back('{1'b1, 1'b0, k >= 12, 1'b0, (k >= 13) ? k - 12 : 0});
      tbl.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 3});
      tbl.push_back('{1'b1, 1'b1, 1'b1, 1'b1, 4});
      tbl.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 5});

      $display("[TB] reset");
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      check("reset_lock", lock_sig, 0);
      check("reset_err_cnt", err_cnt, 0);
      check("reset_bit_cnt", bit_cnt, 0);

      $display("[TB] clean lock table");
      txIdx = 0;
      foreach (tbl[i]) begin
         sendBit(tbl[i].valid, tbl[i].flip, 1'b0);
         check("tbl_lock", lock_sig, tbl[i].expLock);
         check("tbl_err", err_sig, tbl[i].expErr);
         check("tbl_bit_cnt", bit_cnt, tbl[i].expBitCnt);
      end
      check("single_err_cnt", err_cnt, 1);

      $display("[TB] loss and relock");
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      relock(lockAt);
      check("relock_after_reset", lockAt, 12);
      for (int k = 0; k < 5; k++) sendBit(1'b1, 1'b0, 1'b0);
      pulses = 0;
      for (int e = 0; e < LOSS_N; e++) begin
         if (e > 0) begin
            for (int k = 0; k < 3; k++) begin
               sendBit(1'b1, 1'b0, 1'b0);
               if (err_sig) pulses++;
               check("lock_before_loss", lock_sig, 1);
            end
         end
         sendBit(1'b1, 1'b1, 1'b0);
         if (err_sig) pulses++;
      end
      check("loss_lock", lock_sig, 0);
      check("loss_err_cnt", err_cnt, 4);
      check("loss_pulses", pulses, 4);
      relock(lockAt);
      check("relock_after_loss", lockAt, 12);

      $display("[TB] reset while locked");
      for (int k = 0; k < 5; k++) sendBit(1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b1, nextTx(), 1'b0);
      check("midreset_lock", lock_sig, 0);
      check("midreset_err", err_sig, 0);
      check("midreset_err_cnt", err_cnt, 0);
      check("midreset_bit_cnt", bit_cnt, 0);
      relock(lockAt);
      check("relock_after_midreset", lockAt, 12);

      $display("[TB] stalls and clear");
      sendBit(1'b1, 1'b0, 1'b1);
      valids = 0;
      for (int k = 0; k < 200; k++) begin
         bit v = 1'($urandom);
         sendBit(v, 1'b0, 1'b0);
         if (v) valids++;
      end
      check("stall_bit_cnt", bit_cnt, valids);
      check("stall_err_cnt", err_cnt, 0);
      sendBit(1'b1, 1'b1, 1'b1);
      check("clr_err_cnt", err_cnt, 0);
      check("clr_err_pulse", err_sig, 1);
      check("clr_lock", lock_sig, 1);

      $display("[TB] spaced errors and saturation");
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      relock(lockAt);
      for (int e = 0; e < 9; e++) begin
         for (int k = 0; k < 29; k++) sendBit(1'b1, 1'b0, 1'b0);
         sendBit(1'b1, 1'b1, 1'b0);
      end
      check("spaced_lock", lock_sig, 1);
      check("spaced_err_cnt", err_cnt, 9);
      check("small_err_sat", err_cnt_small, 7);
      check("small_bit_sat", bit_cnt_small, 7);

      $display("[TB] all-zero input");
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      lockSeen = 0;
      for (int k = 0; k < 100; k++) begin
         applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
         if (lock_sig) lockSeen = 1;
      end
      check("zero_never_lock", lockSeen, 0);
      check("zero_err_cnt", err_cnt, 0);

      $display("[TB] randomized run");
      garbage = 0;
      for (int k = 0; k < 3000; k++) begin
         if (garbage == 0 && $urandom_range(299) == 0) garbage = 30;
         if ($urandom_range(499) == 0) begin
            applyStimulus(1'b0, 1'($urandom), 1'($urandom), 1'b0);
         end else if (garbage > 0) begin
            garbage--;
            applyStimulus(1'b1, 1'b1, 1'($urandom), 1'b0);
         end else begin
            sendBit($urandom_range(3) != 0, $urandom_range(23) == 0, $urandom_range(96) == 0);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
